iram_loader: RTL

- Boot-time writer for the instruction RAM. The IRAM read path is fixed read-only on port A.
- Accepts a byte stream from a host link (UART/debug bridge) over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word into IRAM port B, starting at BASE_ADDR.
- Holds the core in reset while loading. Reports done and error status.

---
 rtl/iram_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/iram_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | iram_loader: packs a host byte stream into LE words, writes IRAM port B |
// | Optional IRAM_LOAD_CSUM_EN: trailing 32-bit sum check.   Rev 1.0        |
// +------------------------------------------------------------------------+
module iram_loader #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    sclk,
  input  logic                    rstn,
  input  logic                    load_start,
  input  logic [ADDR_WIDTH:0]     load_len,
  input  logic                    load_abort,
  input  logic                    byte_vld,
  input  logic [7:0]              byte_data,
  output logic                    byte_rdy,
  output logic                    ram_cs,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    core_hold,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef IRAM_LOAD_CSUM_EN
    S_CSUM    = 3'd3,
`endif
    S_DONE    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  core_hold_q, core_hold_d;
  logic                  load_busy_q, load_busy_d;
  logic                  load_err_q, load_err_d;
`ifdef IRAM_LOAD_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  assign core_hold = core_hold_q;
  assign load_busy = load_busy_q;
  assign load_err  = load_err_q;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      core_hold_q <= 1'b0;
      load_busy_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef IRAM_LOAD_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      core_hold_q <= core_hold_d;
      load_busy_q <= load_busy_d;
      load_err_q  <= load_err_d;
`ifdef IRAM_LOAD_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    core_hold_d = core_hold_q;
    load_busy_d = load_busy_q;
    load_err_d  = load_err_q;
`ifdef IRAM_LOAD_CSUM_EN
    csum_d      = csum_q;
`endif
    byte_rdy  = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    load_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          load_err_d = 1'b0;
          if (load_len == '0) begin
            state_d = S_DONE;
          end else if (load_len > MAX_LEN) begin
            load_err_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            len_d       = load_len;
            word_cnt_d  = '0;
            byte_cnt_d  = '0;
            core_hold_d = 1'b1;
            load_busy_d = 1'b1;
`ifdef IRAM_LOAD_CSUM_EN
            csum_d      = '0;
`endif
            state_d     = S_COLLECT;
          end
        end
      end

      // Bytes shift in from the top so the first byte ends up in the LSB lane.
      S_COLLECT: begin
        byte_rdy = 1'b1;
        if (load_abort) begin
          load_err_d = 1'b1;
          state_d    = S_DONE;
        end else if (byte_vld) begin
          word_d     = {byte_data, word_q[DATA_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        ram_cs     = 1'b1;
        ram_we     = '1;
        ram_addr   = BASE_ADDR + word_cnt_q[ADDR_WIDTH-1:0];
        ram_wdata  = word_q;
        word_cnt_d = word_cnt_q + 1'b1;
`ifdef IRAM_LOAD_CSUM_EN
        csum_d     = csum_q + word_q;
`endif
        if (load_abort) begin
          load_err_d = 1'b1;
          state_d    = S_DONE;
        end else if (word_cnt_d == len_q) begin
`ifdef IRAM_LOAD_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end

`ifdef IRAM_LOAD_CSUM_EN
      S_CSUM: begin
        byte_rdy = 1'b1;
        if (load_abort) begin
          load_err_d = 1'b1;
          state_d    = S_DONE;
        end else if (byte_vld) begin
          word_d     = {byte_data, word_q[DATA_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_d != csum_q) load_err_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
`endif

      S_DONE: begin
        load_done   = 1'b1;
        core_hold_d = 1'b0;
        load_busy_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
